// File: rtl/hazard_stall_controller_pkg.sv
// Shared types and limits for the pipeline hazard/stall sequencer.
package hazard_pkg;

    typedef enum logic [1:0] {RUN, MD_BUSY, MEM_WAIT} hz_state_t;

    localparam int unsigned MULDIV_LAT_MIN = 2;
    localparam int unsigned MULDIV_LAT_MAX = 16;

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Hazard inputs from the pipeline and per-stage enable/flush controls back to it.
interface hazard_stall_controller_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       IFIDRS1;
    logic [4:0]       IFIDRS2;
    logic [4:0]       IDEXRD;
    logic             IDEXMemRead;
    logic             BranchTaken;
    logic             MulDivStart;
    logic             DMemReq;
    logic             DMemReady;
    logic             PCWrite;
    logic             IFIDWrite;
    logic             IFIDFlush;
    logic             IDEXWrite;
    logic             IDEXFlush;
    logic             EXMEMWrite;
    logic             EXMEMFlush;
    logic             MEMWBFlush;
    logic             MulDivBusy;
    logic [CNT_W-1:0] StallCycles;

    modport master (
        output IFIDRS1, IFIDRS2, IDEXRD, IDEXMemRead, BranchTaken,
               MulDivStart, DMemReq, DMemReady,
        input  PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush,
               EXMEMWrite, EXMEMFlush, MEMWBFlush, MulDivBusy, StallCycles
    );

    modport slave (
        input  IFIDRS1, IFIDRS2, IDEXRD, IDEXMemRead, BranchTaken,
               MulDivStart, DMemReq, DMemReady,
        output PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush,
               EXMEMWrite, EXMEMFlush, MEMWBFlush, MulDivBusy, StallCycles
    );

endinterface

// File: rtl/hazard_stall_controller_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n)
            q <= '0;
        else if (en && (q != '1))
            q <= q + 1'b1;
    end

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline stall/flush sequencer: load-use, taken branch, multi-cycle MUL/DIV and data-memory wait.
module hazard_stall_controller
    import hazard_pkg::*;
#(
    parameter int unsigned MULDIV_LAT = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    hazard_stall_controller_if.slave bus
);

    if (MULDIV_LAT < MULDIV_LAT_MIN || MULDIV_LAT > MULDIV_LAT_MAX) begin : g_bad_lat
        $error("MULDIV_LAT out of range");
    end

    hz_state_t  state, state_nx;
    logic [3:0] md_cnt, md_cnt_nx;
    logic       load_use;

    assign load_use = bus.IDEXMemRead && (bus.IDEXRD != 5'd0) &&
                      ((bus.IDEXRD == bus.IFIDRS1) || (bus.IDEXRD == bus.IFIDRS2));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= RUN;
            md_cnt <= '0;
        end else begin
            state  <= state_nx;
            md_cnt <= md_cnt_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        md_cnt_nx       = md_cnt;
        bus.PCWrite     = 1'b1;
        bus.IFIDWrite   = 1'b1;
        bus.IFIDFlush   = 1'b0;
        bus.IDEXWrite   = 1'b1;
        bus.IDEXFlush   = 1'b0;
        bus.EXMEMWrite  = 1'b1;
        bus.EXMEMFlush  = 1'b0;
        bus.MEMWBFlush  = 1'b0;
        bus.MulDivBusy  = 1'b0;
        if (rst_n) begin
            unique case (state)
                RUN: begin
                    if (bus.DMemReq && !bus.DMemReady) begin
                        bus.PCWrite    = 1'b0;
                        bus.IFIDWrite  = 1'b0;
                        bus.IDEXWrite  = 1'b0;
                        bus.EXMEMWrite = 1'b0;
                        bus.MEMWBFlush = 1'b1;
                        state_nx       = MEM_WAIT;
                    end else if (bus.MulDivStart) begin
                        bus.PCWrite    = 1'b0;
                        bus.IFIDWrite  = 1'b0;
                        bus.IDEXWrite  = 1'b0;
                        bus.EXMEMFlush = 1'b1;
                        md_cnt_nx      = 4'(MULDIV_LAT - 2);
                        state_nx       = MD_BUSY;
                    end else if (bus.BranchTaken) begin
                        bus.IFIDFlush  = 1'b1;
                        bus.IDEXFlush  = 1'b1;
                    end else if (load_use) begin
                        bus.PCWrite    = 1'b0;
                        bus.IFIDWrite  = 1'b0;
                        bus.IDEXFlush  = 1'b1;
                    end
                end
                MD_BUSY: begin
                    // Busy only while the unit is still computing; the md_cnt==0 cycle
                    // is the writeback into EX/MEM and already runs with defaults.
                    if (md_cnt != 4'd0) begin
                        bus.PCWrite    = 1'b0;
                        bus.IFIDWrite  = 1'b0;
                        bus.IDEXWrite  = 1'b0;
                        bus.EXMEMFlush = 1'b1;
                        bus.MulDivBusy = 1'b1;
                        md_cnt_nx      = md_cnt - 4'd1;
                    end else begin
                        state_nx       = RUN;
                    end
                end
                MEM_WAIT: begin
                    if (!bus.DMemReady) begin
                        bus.PCWrite    = 1'b0;
                        bus.IFIDWrite  = 1'b0;
                        bus.IDEXWrite  = 1'b0;
                        bus.EXMEMWrite = 1'b0;
                        bus.MEMWBFlush = 1'b1;
                    end else begin
                        state_nx       = RUN;
                    end
                end
                default: state_nx = RUN;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (!bus.PCWrite),
        .q     (bus.StallCycles)
    );

    a_no_dmem_in_md: assert property (@(posedge clk) disable iff (!rst_n)
        (state == MD_BUSY) |-> !bus.DMemReq);

    a_no_branch_with_md: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.BranchTaken && bus.MulDivStart));

endmodule
